// File: rtl/bird_motion_ctrl.sv
// Bird vertical motion engine: fixed-point position/velocity, semi-implicit Euler per frame.
// Optional BIRD_FRAME_EXT_EN: physics tick from rising edge of frame_en instead of internal divider.
module bird_motion_ctrl #(
    parameter int FRAME_DIV     = 1083334,
    parameter int Y_W           = 12,
    parameter int FRAC_W        = 4,
    parameter int GRAVITY_Q     = 16,
    parameter int JUMP_V_Q      = 192,
    parameter int MAX_V_Q       = 240,
    parameter int X_INIT        = 300,
    parameter int Y_INIT        = 384,
    parameter int CEIL_Y        = 0,
    parameter int FLOOR_Y       = 633,
    parameter int JUMP_COOLDOWN = 0,
    parameter int ANGLE_SHIFT   = 3,
    parameter int ANGLE_MAX     = 30
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     key_jump,
    input  logic                     ai_jump,
    input  logic                     auto_mode,
    input  logic                     game_active,
    input  logic                     frame_en,
    output logic [Y_W-1:0]           bird_x,
    output logic [Y_W-1:0]           bird_y,
    output logic signed [FRAC_W+8:0] bird_vel,
    output logic signed [9:0]        bird_angle,
    output logic                     on_ground,
    output logic                     hit_ceiling,
    output logic                     frame_tick,
    output logic [1:0]               state
);

    localparam int PW   = Y_W + FRAC_W + 1;
    localparam int VW   = FRAC_W + 9;
    localparam int CD_W = $clog2(JUMP_COOLDOWN + 2);

    localparam logic signed [PW-1:0] SPAWN_P = PW'(Y_INIT * (1 << FRAC_W));
    localparam logic signed [PW-1:0] FLOOR_P = PW'(FLOOR_Y * (1 << FRAC_W));
    localparam logic signed [PW-1:0] CEIL_P  = PW'(CEIL_Y * (1 << FRAC_W));
    localparam logic signed [VW-1:0] GRAV_V  = VW'(GRAVITY_Q);
    localparam logic signed [VW-1:0] MAX_V   = VW'(MAX_V_Q);
    localparam logic signed [VW-1:0] JUMP_V  = VW'(-JUMP_V_Q);
    localparam logic signed [VW-1:0] AMAX    = VW'(ANGLE_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLY    = 2'd1,
        LANDED = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic signed [PW-1:0]    pos_q, pos_d, p_new, v_ext;
    logic signed [VW-1:0]    vel_q, vel_d, v_sum, v_fall, v_new;
    logic signed [9:0]       ang_q, ang_d;
    logic [CD_W-1:0]         cd_q, cd_d;
    logic                    pend_q, pend_d;
    logic                    hit_q, hit_d;
    logic                    ft_q;
    logic [2:0]              key_sync;
    logic                    key_rise;
    logic                    req;
    logic                    tick;

`ifdef BIRD_FRAME_EXT_EN
    logic frame_en_q;

    // Remember last frame_en level to find its rising edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) frame_en_q <= 1'b0;
        else     frame_en_q <= frame_en;
    end

    assign tick = frame_en & ~frame_en_q;
`else
    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic             unused_frame_en;

    assign unused_frame_en = frame_en;
    assign tick = (div_cnt == DIV_W'(FRAME_DIV - 1));

    // Free-running frame divider, wraps at FRAME_DIV-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + DIV_W'(1);
    end
`endif

    // Key synchroniser plus one history flop for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) key_sync <= '0;
        else     key_sync <= {key_sync[1:0], key_jump};
    end

    assign key_rise = key_sync[1] & ~key_sync[2];
    assign req      = auto_mode ? ai_jump : key_rise;

    function automatic logic signed [9:0] to_angle(input logic signed [VW-1:0] v);
        logic signed [VW-1:0] s;
        s = v >>> ANGLE_SHIFT;
        if (s > AMAX)       s = AMAX;
        else if (s < -AMAX) s = -AMAX;
        return s[9:0];
    endfunction

    // Candidate velocity and position for this tick
    always_comb begin
        v_sum  = vel_q + GRAV_V;
        v_fall = (v_sum > MAX_V) ? MAX_V : v_sum;
        v_new  = pend_q ? JUMP_V : v_fall;
        v_ext  = v_new;
        p_new  = pos_q + v_ext;
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        vel_d   = vel_q;
        ang_d   = ang_q;
        pend_d  = pend_q;
        cd_d    = cd_q;
        hit_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                pos_d  = SPAWN_P;
                vel_d  = '0;
                ang_d  = '0;
                pend_d = 1'b0;
                cd_d   = '0;
                if (game_active) state_d = FLY;
            end
            FLY, LANDED: begin
                if (tick) begin
                    pend_d = 1'b0;
                    if (pend_q)          cd_d = CD_W'(JUMP_COOLDOWN);
                    else if (cd_q != '0) cd_d = cd_q - CD_W'(1);
                    if (state_q == LANDED && !pend_q) begin
                        vel_d = '0;
                    end else if (p_new >= FLOOR_P) begin
                        pos_d   = FLOOR_P;
                        vel_d   = '0;
                        state_d = LANDED;
                    end else if (p_new <= CEIL_P) begin
                        pos_d   = CEIL_P;
                        vel_d   = '0;
                        hit_d   = 1'b1;
                        state_d = FLY;
                    end else begin
                        pos_d   = p_new;
                        vel_d   = v_new;
                        state_d = FLY;
                    end
                    ang_d = to_angle(vel_d);
                end
            end
            default: state_d = IDLE;
        endcase
        if (!game_active) begin
            state_d = IDLE;
            pos_d   = SPAWN_P;
            vel_d   = '0;
            ang_d   = '0;
            pend_d  = 1'b0;
            cd_d    = '0;
            hit_d   = 1'b0;
        end
        if (req && state_q != IDLE && game_active && cd_d == '0)
            pend_d = 1'b1;
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Physics and flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q  <= SPAWN_P;
            vel_q  <= '0;
            ang_q  <= '0;
            cd_q   <= '0;
            pend_q <= 1'b0;
            hit_q  <= 1'b0;
            ft_q   <= 1'b0;
        end else begin
            pos_q  <= pos_d;
            vel_q  <= vel_d;
            ang_q  <= ang_d;
            cd_q   <= cd_d;
            pend_q <= pend_d;
            hit_q  <= hit_d;
            ft_q   <= tick;
        end
    end

    assign bird_x      = Y_W'(X_INIT);
    assign bird_y      = pos_q[FRAC_W +: Y_W];
    assign bird_vel    = vel_q;
    assign bird_angle  = ang_q;
    assign on_ground   = (state_q == LANDED);
    assign hit_ceiling = hit_q;
    assign frame_tick  = ft_q;
    assign state       = state_q;

endmodule

// File: tb/tb_bird_motion_ctrl.sv
// Directed bench for bird_motion_ctrl: main flight, ceiling clamp and cooldown instances.
// Small FRAME_DIV values keep the frame ticks a few clocks apart.
module tb_bird_motion_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // instance A: default params, FRAME_DIV=4
    logic key_a = 0, ai_a = 0, auto_a = 0, ga_a = 0, fe_a = 0;
    logic [11:0] x_a, y_a;
    logic signed [12:0] vel_a;
    logic signed [9:0] ang_a;
    logic gnd_a, hit_a, ft_a;
    logic [1:0] st_a;

    // instance C: spawn near ceiling
    logic key_c = 0, ai_c = 0, auto_c = 0, ga_c = 0, fe_c = 0;
    logic [11:0] x_c, y_c;
    logic signed [12:0] vel_c;
    logic signed [9:0] ang_c;
    logic gnd_c, hit_c, ft_c;
    logic [1:0] st_c;

    // instance D: cooldown 2, FRAME_DIV=16
    logic key_d = 0, ai_d = 0, auto_d = 0, ga_d = 0, fe_d = 0;
    logic [11:0] x_d, y_d;
    logic signed [12:0] vel_d;
    logic signed [9:0] ang_d;
    logic gnd_d, hit_d, ft_d;
    logic [1:0] st_d;

    bird_motion_ctrl #(.FRAME_DIV(4)) u_a (
        .clk(clk), .rst(rst), .key_jump(key_a), .ai_jump(ai_a),
        .auto_mode(auto_a), .game_active(ga_a), .frame_en(fe_a),
        .bird_x(x_a), .bird_y(y_a), .bird_vel(vel_a), .bird_angle(ang_a),
        .on_ground(gnd_a), .hit_ceiling(hit_a), .frame_tick(ft_a), .state(st_a)
    );

    bird_motion_ctrl #(.FRAME_DIV(4), .Y_INIT(10)) u_c (
        .clk(clk), .rst(rst), .key_jump(key_c), .ai_jump(ai_c),
        .auto_mode(auto_c), .game_active(ga_c), .frame_en(fe_c),
        .bird_x(x_c), .bird_y(y_c), .bird_vel(vel_c), .bird_angle(ang_c),
        .on_ground(gnd_c), .hit_ceiling(hit_c), .frame_tick(ft_c), .state(st_c)
    );

    bird_motion_ctrl #(.FRAME_DIV(16), .JUMP_COOLDOWN(2)) u_d (
        .clk(clk), .rst(rst), .key_jump(key_d), .ai_jump(ai_d),
        .auto_mode(auto_d), .game_active(ga_d), .frame_en(fe_d),
        .bird_x(x_d), .bird_y(y_d), .bird_vel(vel_d), .bird_angle(ang_d),
        .on_ground(gnd_d), .hit_ceiling(hit_d), .frame_tick(ft_d), .state(st_d)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_tick(input int which, input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if ((which == 0 && ft_a) || (which == 1 && ft_c) || (which == 2 && ft_d)) begin
                got = 1'b1;
                break;
            end
        end
        n_tests++;
        assert (got === 1'b1)
        else begin
            n_fail++;
            $error("FAIL %s tick_timeout observed=0 expected=1", tag);
        end
    endtask

    task automatic pulse_ai_d();
        ai_d = 1;
        @(posedge clk);
        #1;
        ai_d = 0;
    endtask

    initial begin
        int maxv;
        logic landed;

        #12;
        chk("rst_y", y_a, 384);
        chk("rst_x", x_a, 300);
        chk("rst_vel", $signed(vel_a), 0);
        chk("rst_ang", $signed(ang_a), 0);
        chk("rst_state", st_a, 0);
        chk("rst_gnd", gnd_a, 0);
        chk("rst_hit", hit_a, 0);
        chk("rst_ft", ft_a, 0);
        @(negedge clk);
        rst = 0;

        ga_a = 1;
        @(posedge clk);
        #1;
        chk("fly_entry", st_a, 1);

        wait_tick(0, "t1");
        chk("t1_y", y_a, 385);
        chk("t1_vel", $signed(vel_a), 16);
        chk("t1_ang", $signed(ang_a), 2);
        chk("t1_state", st_a, 1);
        wait_tick(0, "t2");
        chk("t2_y", y_a, 387);
        chk("t2_vel", $signed(vel_a), 32);
        chk("t2_ang", $signed(ang_a), 4);
        wait_tick(0, "t3");
        chk("t3_y", y_a, 390);
        chk("t3_vel", $signed(vel_a), 48);
        chk("t3_ang", $signed(ang_a), 6);

        auto_a = 1;
        ai_a = 1;
        @(posedge clk);
        #1;
        ai_a = 0;
        wait_tick(0, "jump");
        chk("jump_vel", $signed(vel_a), -192);
        chk("jump_y", y_a, 378);
        chk("jump_ang", $signed(ang_a), -24);

        maxv = -9999;
        landed = 1'b0;
        for (int k = 0; k < 80; k++) begin
            wait_tick(0, "fall");
            if ($signed(vel_a) > maxv) maxv = $signed(vel_a);
            if (gnd_a) begin
                landed = 1'b1;
                break;
            end
        end
        chk("fall_maxv", maxv, 240);
        chk("land_flag", landed, 1);
        chk("land_y", y_a, 633);
        chk("land_state", st_a, 2);
        chk("land_vel", $signed(vel_a), 0);
        wait_tick(0, "landed_hold");
        chk("hold_y", y_a, 633);
        chk("hold_vel", $signed(vel_a), 0);
        chk("hold_gnd", gnd_a, 1);

        auto_a = 0;
        key_a = 1;
        wait_tick(0, "key_jump");
        key_a = 0;
        chk("kj_y", y_a, 621);
        chk("kj_state", st_a, 1);
        chk("kj_vel", $signed(vel_a), -192);
        chk("kj_gnd", gnd_a, 0);

        @(posedge clk);
        #3;
        rst = 1;
        #1;
        chk("mid_rst_y", y_a, 384);
        chk("mid_rst_vel", $signed(vel_a), 0);
        chk("mid_rst_ang", $signed(ang_a), 0);
        chk("mid_rst_state", st_a, 0);
        chk("mid_rst_ft", ft_a, 0);
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
        chk("re_fly", st_a, 1);
        wait_tick(0, "re_t1");
        chk("re_t1_y", y_a, 385);

        auto_a = 1;
        ai_a = 1;
        @(posedge clk);
        #1;
        ai_a = 0;
        ga_a = 0;
        @(posedge clk);
        #1;
        chk("idle_state", st_a, 0);
        chk("idle_y", y_a, 384);
        chk("idle_vel", $signed(vel_a), 0);
        ga_a = 1;
        @(posedge clk);
        #1;
        chk("react_state", st_a, 1);
        wait_tick(0, "react_t1");
        chk("react_vel", $signed(vel_a), 16);
        chk("react_y", y_a, 385);

        wait_tick(1, "c_sync");
        ga_c = 1;
        @(posedge clk);
        #1;
        auto_c = 1;
        ai_c = 1;
        @(posedge clk);
        #1;
        ai_c = 0;
        wait_tick(1, "c_jump");
        chk("ceil_y", y_c, 0);
        chk("ceil_vel", $signed(vel_c), 0);
        chk("ceil_hit", hit_c, 1);
        chk("ceil_state", st_c, 1);
        @(posedge clk);
        #1;
        chk("ceil_hit_clr", hit_c, 0);

        wait_tick(2, "d_sync");
        ga_d = 1;
        @(posedge clk);
        #1;
        auto_d = 1;
        pulse_ai_d();
        wait_tick(2, "d_n");
        chk("cd_n_y", y_d, 372);
        chk("cd_n_vel", $signed(vel_d), -192);
        pulse_ai_d();
        wait_tick(2, "d_n1");
        chk("cd_n1_y", y_d, 361);
        chk("cd_n1_vel", $signed(vel_d), -176);
        pulse_ai_d();
        wait_tick(2, "d_n2");
        chk("cd_n2_y", y_d, 351);
        chk("cd_n2_vel", $signed(vel_d), -160);
        pulse_ai_d();
        wait_tick(2, "d_n3");
        chk("cd_n3_y", y_d, 339);
        chk("cd_n3_vel", $signed(vel_d), -192);
        wait_tick(2, "d_n4");
        chk("cd_n4_y", y_d, 328);
        wait_tick(2, "d_n5");
        chk("cd_n5_y", y_d, 318);

        auto_d = 0;
        for (int e = 0; e < 3; e++) begin
            key_d = 1;
            repeat (2) @(posedge clk);
            key_d = 0;
            repeat (2) @(posedge clk);
        end
        wait_tick(2, "d_multi");
        chk("multi_y", y_d, 306);
        chk("multi_vel", $signed(vel_d), -192);
        wait_tick(2, "d_after");
        chk("after_y", y_d, 295);
        chk("after_vel", $signed(vel_d), -176);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bird_motion_ctrl.md
Name: bird_motion_ctrl

Overview:
Parametrised vertical-motion engine for the player bird. It keeps position and velocity in sub-pixel fixed point and updates them once per frame tick using semi-implicit Euler. It latches jump requests between ticks, enforces a jump cooldown, and reports ground, ceiling and state flags. It sits between input/AI logic and the sprite renderer/collision checker, and runs in the HDMI clock domain.

Parameters:
FRAME_DIV, 1083334, clk cycles per frame tick (65 MHz / 60 Hz)
Y_W, 12, integer pixel width of bird_x/bird_y
FRAC_W, 4, fractional bits of position/velocity (1/16 px)
GRAVITY_Q, 16, gravity per frame, Q.FRAC_W (1.0 px/frame²)
JUMP_V_Q, 192, jump speed magnitude, Q.FRAC_W (12 px/frame)
MAX_V_Q, 240, terminal downward velocity, Q.FRAC_W (15 px/frame)
X_INIT, 300, fixed bird_x
Y_INIT, 384, spawn bird_y
CEIL_Y, 0, top clamp (px)
FLOOR_Y, 633, bottom clamp (px) = ground 668 − bird height 35
JUMP_COOLDOWN, 0, frames after an applied jump during which requests are discarded
ANGLE_SHIFT, 3, right-shift from velocity_q to angle
ANGLE_MAX, 30, angle saturation magnitude

Ports:
clk  in  1  HDMI pixel clock; sole clock
rst  in  1  asynchronous, active-high reset
key_jump  in  1  raw button level (manual mode), asynchronous
ai_jump  in  1  single-cycle jump pulse from AI (auto mode)
auto_mode  in  1  1 = ai_jump is the source, 0 = key_jump is the source
game_active  in  1  1 = run physics, 0 = hold at spawn
frame_en  in  1  external frame strobe; used only with BIRD_FRAME_EXT_EN
bird_x  out  Y_W  constant X_INIT
bird_y  out  Y_W  integer part of position
bird_vel  out  FRAC_W+9  signed velocity, Q.FRAC_W, negative = up
bird_angle  out  10  signed two's-complement tilt
on_ground  out  1  high while in LANDED
hit_ceiling  out  1  one-cycle pulse on ceiling clamp
frame_tick  out  1  one-cycle pulse on each physics update
state  out  2  0 IDLE, 1 FLY, 2 LANDED

Behaviour:
- Reset (async, rst=1): bird_y=Y_INIT, bird_x=X_INIT, bird_vel=0, bird_angle=0, on_ground=0, hit_ceiling=0, frame_tick=0, state=IDLE. Frame counter, cooldown, pending request and key synchroniser are all cleared.
- Frame counter: counts 0..FRAME_DIV−1 and wraps. frame_tick is registered high for the cycle after the counter reaches FRAME_DIV−1. The counter runs in every state.
- Jump source: key_jump passes through a 2-flop synchroniser, then a rising-edge detector. The request is the edge pulse (auto_mode=0) or ai_jump (auto_mode=1).
  - A request sets pend_jump when cooldown==0 and state≠IDLE; otherwise the request is dropped.
  - pend_jump is cleared on the tick that consumes it. Multiple requests within one frame count as one jump.
- IDLE: entered when game_active=0 from any state, on the next cycle. Position and velocity are held at spawn values; pend_jump and cooldown are cleared. When game_active=1, go to FLY on the next cycle.
- FLY, on each tick:
  - Velocity: if pend_jump, v=−JUMP_V_Q and cooldown=JUMP_COOLDOWN. Otherwise v=min(v+GRAVITY_Q, MAX_V_Q). If no jump is applied and cooldown>0, cooldown decrements by 1.
  - Position: p'=p+v (new v), using signed width Y_W+FRAC_W+1.
  - If p' ≥ FLOOR_Y<<FRAC_W: p=FLOOR_Y<<FRAC_W, v=0, state→LANDED.
  - Else if p' ≤ CEIL_Y<<FRAC_W: p=CEIL_Y<<FRAC_W, v=0, hit_ceiling=1 for one cycle.
  - Else p=p'.
- LANDED: position is held and v=0 on every tick. A tick with pend_jump applies the jump exactly as in FLY and returns to FLY.
- bird_angle: updated on every tick as bird_vel>>>ANGLE_SHIFT, saturated to ±ANGLE_MAX and sign-extended to 10 bits.
- Outputs change only on the tick cycle, except on IDLE entry and reset.
- Priorities:
  - game_active=0 overrides a tick.
  - A request arriving in the tick cycle itself is latched for the next tick.
  - The floor clamp is checked before the ceiling clamp.

Optional Feature:
BIRD_FRAME_EXT_EN
- Defined: the internal divider is removed. The physics tick is a rising edge of frame_en (frame_en is synchronous to clk), and frame_tick is registered one cycle after that edge.
- Undefined: frame_en is ignored and the internal FRAME_DIV divider is used.

Test Plan:
- FRAME_DIV=4, default Q params, game_active 0→1, no jumps → ticks 1-3 give bird_y 385, 387, 390 and bird_vel 16, 32, 48; bird_angle 2, 4, 6; state FLY.
- After tick 3, ai_jump pulse with auto_mode=1 → next tick bird_vel=−192, bird_y=378, bird_angle=−24.
- Free fall from Y_INIT → bird_vel saturates at 240; bird_y clamps to 633, on_ground=1, state=LANDED, bird_vel=0 on later ticks. key_jump rising edge (auto_mode=0) → bird_y=621, state FLY.
- Y_INIT=10, jump → y computes to −2, clamps to bird_y=0, bird_vel=0, hit_ceiling high exactly 1 cycle.
- JUMP_COOLDOWN=2: jump applied at tick N; requests before ticks N+1 and N+2 are dropped; a request after tick N+2 is applied at tick N+3. Three key edges within one frame → one jump.
- rst asserted mid-flight → all outputs at reset values in the same cycle. game_active 1→0 with pend_jump set → IDLE, bird_y=384, and no jump on re-activation.
